// File: rtl/phase_frame_serializer.sv
// Serializes one ROWS x COLS x PW-bit phase frame MSB-first, row-major, one bit per clk.
// Optional even-parity trailer bit is enabled by defining SER_PARITY_EN.
module phase_frame_serializer #(
    parameter  int ROWS = 5,
    parameter  int COLS = 3,
    parameter  int PW   = 4,
    localparam int N    = ROWS * COLS * PW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:N-1] phi_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         bit_out,
    output logic         bit_valid,
    output logic         frame_start,
    output logic         frame_done,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = N + 1;
`else
    localparam int FRAME_LEN = N;
`endif
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s, cnt_inc_s;
    logic [0:N-1]   shreg_r, shreg_s;
    logic           bit_out_r, bit_out_s;
    logic           bit_valid_r, bit_valid_s;
    logic           start_r, start_s;
    logic           done_r, done_s;
    logic           last_s, load_ready_s, accept_s;

`ifdef SER_PARITY_EN
    logic           parity_r, parity_s;

    function automatic logic even_parity(input logic [0:N-1] frame);
        return ^frame;
    endfunction
`endif

    assign last_s       = (state_r == SHIFT) && (cnt_r == LAST);
    assign load_ready_s = (state_r == IDLE) || last_s;
    assign accept_s     = load_valid && load_ready_s;
    assign cnt_inc_s    = cnt_r + CW'(1);

    // Next-state and next-output decode; the frame is captured only on accept.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        shreg_s     = shreg_r;
        bit_out_s   = 1'b0;
        bit_valid_s = 1'b0;
        start_s     = 1'b0;
        done_s      = 1'b0;
`ifdef SER_PARITY_EN
        parity_s    = parity_r;
`endif
        case (state_r)
            IDLE, SHIFT: begin
                if (accept_s) begin
                    // First bit leaves straight from phi_in; the rest waits in shreg.
                    state_s     = SHIFT;
                    cnt_s       = {CW{1'b0}};
                    shreg_s     = {phi_in[1:N-1], 1'b0};
                    bit_out_s   = phi_in[0];
                    bit_valid_s = 1'b1;
                    start_s     = 1'b1;
`ifdef SER_PARITY_EN
                    parity_s    = even_parity(phi_in);
`endif
                end else if ((state_r == IDLE) || last_s) begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                    shreg_s = {N{1'b0}};
                end else begin
                    cnt_s       = cnt_inc_s;
                    shreg_s     = {shreg_r[1:N-1], 1'b0};
                    bit_valid_s = 1'b1;
                    done_s      = (cnt_inc_s == LAST);
`ifdef SER_PARITY_EN
                    if (cnt_inc_s == CW'(N)) begin
                        bit_out_s = parity_r;
                    end else begin
                        bit_out_s = shreg_r[0];
                    end
`else
                    bit_out_s   = shreg_r[0];
`endif
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
                shreg_s = {N{1'b0}};
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= {CW{1'b0}};
            shreg_r     <= {N{1'b0}};
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            start_r     <= 1'b0;
            done_r      <= 1'b0;
`ifdef SER_PARITY_EN
            parity_r    <= 1'b0;
`endif
        end else begin
            cnt_r       <= cnt_s;
            shreg_r     <= shreg_s;
            bit_out_r   <= bit_out_s;
            bit_valid_r <= bit_valid_s;
            start_r     <= start_s;
            done_r      <= done_s;
`ifdef SER_PARITY_EN
            parity_r    <= parity_s;
`endif
        end
    end

    assign load_ready  = load_ready_s;
    assign bit_out     = bit_out_r;
    assign bit_valid   = bit_valid_r;
    assign frame_start = start_r;
    assign frame_done  = done_r;
    assign busy        = bit_valid_r;

endmodule

// File: tb/tb_phase_frame_serializer.sv
// Directed bench for phase_frame_serializer: single frame, back-to-back, ignored load,
// mid-frame reset and (with SER_PARITY_EN) the parity trailer.
module tb_phase_frame_serializer;

    localparam int N = 60;
`ifdef SER_PARITY_EN
    localparam int LEN = N + 1;
`else
    localparam int LEN = N;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [0:N-1] phi_in;
    logic         load_ready, bit_out, bit_valid, frame_start, frame_done, busy;

    int vectors = 0;
    int errors  = 0;

    logic cap_bit[256], cap_valid[256], cap_start[256], cap_done[256];
    logic cap_ready[256], cap_busy[256];
    int   cap_n;

    localparam logic [0:N-1] FRAME_A = 60'hF00F00F00F00F00;
    localparam logic [0:N-1] FRAME_B = 60'hA5C31E7F0D92B46;

    phase_frame_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .phi_in      (phi_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Records n output samples on the falling edge; no checking here.
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_bit[cap_n]   = bit_out;
            cap_valid[cap_n] = bit_valid;
            cap_start[cap_n] = frame_start;
            cap_done[cap_n]  = frame_done;
            cap_ready[cap_n] = load_ready;
            cap_busy[cap_n]  = busy;
            cap_n++;
        end
    endtask

    function automatic logic exp_bit(input logic [0:N-1] f, input int k);
        if (k < N) return f[k];
        return ^f;
    endfunction

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b0; phi_in = '0; cap_n = 0;
        collect(2);
        vectors++;
        if ({cap_bit[1], cap_valid[1], cap_start[1], cap_done[1], cap_busy[1]} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {cap_bit[1], cap_valid[1], cap_start[1], cap_done[1], cap_busy[1]});
        end
        rst = 1'b0;
        collect(1);
        vectors++;
        if (cap_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_load_ready: got %b expected 1", cap_ready[2]);
        end
        vectors++;
        if (cap_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b expected 0", cap_valid[2]);
        end
    endtask

    task automatic test_single_frame();
        logic [0:N-1] rx;
        logic [4:0]   got, want;
        cap_n = 0;
        phi_in = FRAME_A; load_valid = 1'b1;
        vectors++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_idle: got %b expected 1", load_ready);
        end
        collect(1);
        load_valid = 1'b0;
        collect(LEN);
        for (int k = 0; k < LEN; k++) begin
            got  = {cap_valid[k], cap_bit[k], cap_start[k], cap_done[k], cap_busy[k]};
            want = {1'b1, exp_bit(FRAME_A, k), (k == 0), (k == LEN - 1), 1'b1};
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL single_bit[%0d]: got %b expected %b", k, got, want);
            end
        end
        vectors++;
        if ({cap_valid[LEN], cap_done[LEN], cap_bit[LEN]} !== 3'b000) begin
            errors++;
            $display("FAIL single_after_end: got %b expected 000",
                     {cap_valid[LEN], cap_done[LEN], cap_bit[LEN]});
        end
        for (int k = 0; k < N; k++) rx[k] = cap_bit[k];
        vectors++;
        if (rx !== FRAME_A) begin
            errors++;
            $display("FAIL single_rebuild: got %h expected %h", rx, FRAME_A);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, want;
        int         j;
        cap_n = 0;
        phi_in = FRAME_A; load_valid = 1'b1;
        collect(1);
        phi_in = FRAME_B;
        collect(LEN);
        load_valid = 1'b0;
        collect(LEN);
        for (int k = 0; k < 2 * LEN; k++) begin
            j    = (k < LEN) ? k : k - LEN;
            got  = {cap_valid[k], cap_bit[k], cap_start[k], cap_done[k]};
            want = {1'b1, exp_bit((k < LEN) ? FRAME_A : FRAME_B, j), (j == 0), (j == LEN - 1)};
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL b2b_bit[%0d]: got %b expected %b", k, got, want);
            end
        end
        vectors++;
        if ({cap_ready[1], cap_ready[LEN - 1]} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_load_ready: got %b expected 01", {cap_ready[1], cap_ready[LEN - 1]});
        end
        vectors++;
        if (cap_valid[2 * LEN] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_after_end: got %b expected 0", cap_valid[2 * LEN]);
        end
    endtask

    task automatic test_ignore_load();
        cap_n = 0;
        phi_in = FRAME_A; load_valid = 1'b1;
        collect(1);
        load_valid = 1'b0;
        collect(9);
        phi_in = FRAME_B; load_valid = 1'b1;
        collect(2);
        load_valid = 1'b0;
        collect(LEN + 1 - 12);
        vectors++;
        if ({cap_ready[10], cap_ready[11]} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_load_ready: got %b expected 00", {cap_ready[10], cap_ready[11]});
        end
        for (int k = 0; k < LEN; k++) begin
            vectors++;
            if ({cap_valid[k], cap_bit[k]} !== {1'b1, exp_bit(FRAME_A, k)}) begin
                errors++;
                $display("FAIL ignore_bit[%0d]: got %b expected %b", k,
                         {cap_valid[k], cap_bit[k]}, {1'b1, exp_bit(FRAME_A, k)});
            end
        end
        vectors++;
        if (cap_valid[LEN] !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_second_frame: got %b expected 0", cap_valid[LEN]);
        end
    endtask

    task automatic test_abort();
        logic [3:0] got, want;
        cap_n = 0;
        phi_in = FRAME_B; load_valid = 1'b1;
        collect(1);
        load_valid = 1'b0;
        collect(23);
        rst = 1'b1;
        collect(1);
        rst = 1'b0;
        vectors++;
        if ({cap_valid[24], cap_done[24], cap_start[24], cap_bit[24]} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_outputs: got %b expected 0000",
                     {cap_valid[24], cap_done[24], cap_start[24], cap_bit[24]});
        end
        phi_in = FRAME_A; load_valid = 1'b1;
        collect(1);
        load_valid = 1'b0;
        collect(LEN);
        for (int k = 0; k < LEN; k++) begin
            got  = {cap_valid[25 + k], cap_bit[25 + k], cap_start[25 + k], cap_done[25 + k]};
            want = {1'b1, exp_bit(FRAME_A, k), (k == 0), (k == LEN - 1)};
            vectors++;
            if (got !== want) begin
                errors++;
                $display("FAIL abort_restart_bit[%0d]: got %b expected %b", k, got, want);
            end
        end
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        logic [0:N-1] frames[2];
        logic         par_exp[2];
        frames[0] = 60'h1;  par_exp[0] = 1'b1;
        frames[1] = 60'h0;  par_exp[1] = 1'b0;
        for (int f = 0; f < 2; f++) begin
            cap_n = 0;
            phi_in = frames[f]; load_valid = 1'b1;
            collect(1);
            load_valid = 1'b0;
            collect(LEN);
            vectors++;
            if ({cap_valid[N], cap_bit[N], cap_done[N], cap_done[N - 1]} !== {1'b1, par_exp[f], 2'b10}) begin
                errors++;
                $display("FAIL parity_bit[frame %0d]: got %b expected %b", f,
                         {cap_valid[N], cap_bit[N], cap_done[N], cap_done[N - 1]}, {1'b1, par_exp[f], 2'b10});
            end
            vectors++;
            if ({cap_bit[N - 1], cap_valid[N + 1]} !== {frames[f][N - 1], 1'b0}) begin
                errors++;
                $display("FAIL parity_tail[frame %0d]: got %b expected %b", f,
                         {cap_bit[N - 1], cap_valid[N + 1]}, {frames[f][N - 1], 1'b0});
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignore_load();
        test_abort();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
